// File: rtl/lbp_cell_histogram.sv
// lbp_cell_histogram
// Builds a 59-bin uniform-LBP histogram for one image cell. Raw 8-bit LBP codes
// are mapped to a bin through a registered LUT, then counted in a saturating
// per-bin counter. After CELL_PIXELS codes the histogram is streamed out over a
// valid/ready handshake, and each bin is zeroed as it is sent, so the next cell
// starts from an empty histogram without a separate clear pass.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | after reset: zero one bin per cycle, bins 0..58
// S_ACCUM | accept codes until CELL_PIXELS have been taken
// S_DRAIN | no new codes; wait for the last increment to commit
// S_DUMP  | stream bins 0..58, clearing each one on its handshake

module lbp_cell_histogram #(
    parameter int CELL_PIXELS = 64,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   code_valid,
    input  logic [7:0]             code_in,
    output logic                   code_ready,
    output logic                   hist_valid,
    input  logic                   hist_ready,
    output logic [5:0]             hist_bin,
    output logic [COUNT_WIDTH-1:0] hist_count,
    output logic                   hist_last,
    output logic                   cell_done,
    output logic                   busy
);

    localparam int                     NUM_BINS   = 59;
    localparam logic [5:0]             LAST_BIN   = 6'd58;
    localparam logic [15:0]            PIX_TARGET = 16'(CELL_PIXELS);
    localparam logic [15:0]            PIX_FINAL  = 16'(CELL_PIXELS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    // Uniform patterns (at most two circular 0/1 transitions) get bins 1..58 in
    // ascending code order; every other code lands in bin 0.
    typedef logic [255:0][5:0] lut_t;

    function automatic lut_t build_lut();
        lut_t       table_v;
        logic [7:0] code_v;
        int         bin_v;
        table_v = '0;
        bin_v   = 1;
        for (int c = 0; c < 256; c++) begin
            code_v = 8'(c);
            if ($countones(code_v ^ {code_v[0], code_v[7:1]}) <= 2) begin
                table_v[code_v] = 6'(bin_v);
                bin_v++;
            end
        end
        return table_v;
    endfunction

    localparam lut_t UNIFORM_LUT = build_lut();

    typedef enum logic [1:0] {
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DUMP
    } state_t;

    state_t                 state_q;
    logic [5:0]             ptr_q;
    logic [15:0]            pix_cnt_q;
    logic                   cell_done_q;

    logic [5:0]             lut_bin_q;
    logic                   lut_valid_q;
    logic [5:0]             inc_bin_q;
    logic                   inc_valid_q;

    logic [COUNT_WIDTH-1:0] bins_q [NUM_BINS];

    logic                   in_dump;
    logic                   accept;
    logic                   dump_fire;
    logic [COUNT_WIDTH-1:0] inc_cur;
    logic [COUNT_WIDTH-1:0] inc_count_d;

    assign in_dump   = (state_q == S_DUMP);
    assign code_ready = (state_q == S_ACCUM) && (pix_cnt_q < PIX_TARGET);
    assign accept    = code_valid && code_ready;
    assign dump_fire = in_dump && hist_ready;

    // Stage-2 read happens in the same cycle as the write, so back-to-back hits
    // on one bin always see the previous increment.
    assign inc_cur     = bins_q[inc_bin_q];
    assign inc_count_d = (inc_cur == COUNT_MAX) ? inc_cur : inc_cur + COUNT_WIDTH'(1);

    assign hist_valid = in_dump;
    assign hist_bin   = in_dump ? ptr_q : 6'd0;
    assign hist_count = in_dump ? bins_q[ptr_q] : '0;
    assign hist_last  = in_dump && (ptr_q == LAST_BIN);
    assign cell_done  = cell_done_q;
    assign busy       = (state_q != S_ACCUM);

    // Two-stage pipeline: registered LUT lookup, then the increment stage.
    // Only the valid bits need a reset; the bin fields are qualified by them.
    always_ff @(posedge clock) begin
        if (reset) begin
            lut_valid_q <= 1'b0;
            inc_valid_q <= 1'b0;
        end else begin
            lut_valid_q <= accept;
            inc_valid_q <= lut_valid_q;
        end
        lut_bin_q <= UNIFORM_LUT[code_in];
        inc_bin_q <= lut_bin_q;
    end

    // Bin storage: clear sweep, clear-on-read, or saturating increment.
    // The FSM guarantees the three never overlap, the priority is only a safeguard.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                bins_q[ptr_q] <= '0;
            end else if (dump_fire) begin
                bins_q[ptr_q] <= '0;
            end else if (inc_valid_q) begin
                bins_q[inc_bin_q] <= inc_count_d;
            end
        end
    end

    // Cell sequencing: clear sweep, accumulation, drain and readout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            ptr_q       <= 6'd0;
            pix_cnt_q   <= 16'd0;
            cell_done_q <= 1'b0;
        end else begin
            cell_done_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (ptr_q == LAST_BIN) begin
                        state_q <= S_ACCUM;
                        ptr_q   <= 6'd0;
                    end else begin
                        ptr_q <= ptr_q + 6'd1;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        pix_cnt_q <= pix_cnt_q + 16'd1;
                        if (pix_cnt_q == PIX_FINAL) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Once stage 1 is empty, the last increment commits on this
                    // same edge, so the dump can start next cycle.
                    if (!lut_valid_q) begin
                        state_q     <= S_DUMP;
                        ptr_q       <= 6'd0;
                        cell_done_q <= 1'b1;
                    end
                end
                S_DUMP: begin
                    if (hist_ready) begin
                        if (ptr_q == LAST_BIN) begin
                            state_q   <= S_ACCUM;
                            ptr_q     <= 6'd0;
                            pix_cnt_q <= 16'd0;
                        end else begin
                            ptr_q <= ptr_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    ptr_q   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_cell_histogram.sv
// Directed bench for lbp_cell_histogram: default instance (64 codes, 8-bit
// counts) plus a small instance (20 codes, 4-bit counts) for saturation.
module tb_lbp_cell_histogram;

    logic       clock;
    logic       reset;
    logic       code_valid;
    logic [7:0] code_in;
    logic       code_ready;
    logic       hist_valid;
    logic       hist_ready;
    logic [5:0] hist_bin;
    logic [7:0] hist_count;
    logic       hist_last;
    logic       cell_done;
    logic       busy;

    logic       code_valid2;
    logic [7:0] code_in2;
    logic       code_ready2;
    logic       hist_valid2;
    logic       hist_ready2;
    logic [5:0] hist_bin2;
    logic [3:0] hist_count2;
    logic       hist_last2;
    logic       cell_done2;
    logic       busy2;

    int checks   = 0;
    int failures = 0;
    int exp_bin [59];

    lbp_cell_histogram #(.CELL_PIXELS(64), .COUNT_WIDTH(8)) u_dut (
        .clock(clock), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .code_ready(code_ready), .hist_valid(hist_valid), .hist_ready(hist_ready),
        .hist_bin(hist_bin), .hist_count(hist_count), .hist_last(hist_last),
        .cell_done(cell_done), .busy(busy)
    );

    lbp_cell_histogram #(.CELL_PIXELS(20), .COUNT_WIDTH(4)) u_sat (
        .clock(clock), .reset(reset), .code_valid(code_valid2), .code_in(code_in2),
        .code_ready(code_ready2), .hist_valid(hist_valid2), .hist_ready(hist_ready2),
        .hist_bin(hist_bin2), .hist_count(hist_count2), .hist_last(hist_last2),
        .cell_done(cell_done2), .busy(busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 59; i++) exp_bin[i] = 0;
    endtask

    // Reset held for two edges, then the 59-cycle CLEAR sweep is timed.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        check({tag, "_rst_code_ready"}, 32'(code_ready), 0);
        check({tag, "_rst_hist_valid"}, 32'(hist_valid), 0);
        check({tag, "_rst_hist_bin"},   32'(hist_bin), 0);
        check({tag, "_rst_hist_count"}, 32'(hist_count), 0);
        check({tag, "_rst_hist_last"},  32'(hist_last), 0);
        check({tag, "_rst_cell_done"},  32'(cell_done), 0);
        check({tag, "_rst_busy"},       32'(busy), 1);
        reset = 1'b0;
        check({tag, "_c0_hist_bin"}, 32'(hist_bin), 0);
        for (int k = 1; k <= 58; k++) begin
            tick();
            check({tag, "_clear_code_ready"}, 32'(code_ready), 0);
            check({tag, "_clear_busy"}, 32'(busy), 1);
        end
        tick();
        check({tag, "_c59_code_ready"}, 32'(code_ready), 1);
        check({tag, "_c59_busy"}, 32'(busy), 0);
    endtask

    // Presents n copies of a code; each one is accepted on the edge after
    // code_ready is seen high. Leaves the bench in cycle N+1 of the last accept.
    task automatic send(input string tag, input logic [7:0] c, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            code_valid = 1'b1;
            code_in    = c;
            w = 0;
            while (!code_ready && w < 200) begin
                tick();
                w++;
            end
            check({tag, "_send_ready"}, 32'(code_ready), 1);
            tick();
        end
        code_valid = 1'b0;
    endtask

    task automatic wait_dump(input string tag);
        int w;
        w = 0;
        while (!hist_valid && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_dump_start"}, 32'(hist_valid), 1);
        check({tag, "_cell_done"}, 32'(cell_done), 1);
    endtask

    // Reads all 59 beats, checking index, count and last flag every cycle the
    // block is presenting; a stalled beat must repeat unchanged.
    task automatic dump(input string tag, input bit stall_mode, input bit check_len);
        int  beat;
        int  cyc;
        int  stall_left;
        bit  stall_used;
        beat = 0;
        cyc = 0;
        stall_left = 0;
        stall_used = 1'b0;
        while (beat < 59 && cyc < 1000) begin
            if (stall_mode && beat == 20 && !stall_used) begin
                stall_left = 100;
                stall_used = 1'b1;
            end
            if (stall_left > 0) begin
                hist_ready = 1'b0;
                stall_left--;
            end else if (stall_mode) begin
                hist_ready = ((cyc % 3) != 2);
            end else begin
                hist_ready = 1'b1;
            end
            check({tag, "_valid"}, 32'(hist_valid), 1);
            if (!hist_valid) break;
            check({tag, "_bin"}, 32'(hist_bin), 32'(beat));
            check({tag, "_count"}, 32'(hist_count), 32'(exp_bin[beat]));
            check({tag, "_last"}, 32'(hist_last), (beat == 58) ? 32'd1 : 32'd0);
            check({tag, "_code_ready_low"}, 32'(code_ready), 0);
            if (cyc == 1) check({tag, "_cell_done_pulse"}, 32'(cell_done), 0);
            if (hist_ready) beat++;
            tick();
            cyc++;
        end
        hist_ready = 1'b0;
        code_valid = 1'b0;
        check({tag, "_beats"}, 32'(beat), 59);
        if (check_len) check({tag, "_dump_cycles"}, 32'(cyc), 59);
        check({tag, "_post_valid"}, 32'(hist_valid), 0);
        check({tag, "_post_code_ready"}, 32'(code_ready), 1);
    endtask

    initial begin
        int w;
        reset       = 1'b1;
        code_valid  = 1'b0;
        code_in     = 8'h00;
        hist_ready  = 1'b0;
        code_valid2 = 1'b0;
        code_in2    = 8'h00;
        hist_ready2 = 1'b0;

        // Cell 1: 64 x 0x00 back-to-back, exact drain timing and dump length.
        do_reset("init");
        send("c1", 8'h00, 64);
        check("c1_n1_hist_valid", 32'(hist_valid), 0);
        check("c1_n1_code_ready", 32'(code_ready), 0);
        check("c1_n1_busy", 32'(busy), 1);
        tick();
        check("c1_n2_hist_valid", 32'(hist_valid), 0);
        tick();
        check("c1_n3_hist_valid", 32'(hist_valid), 1);
        check("c1_n3_cell_done", 32'(cell_done), 1);
        clear_exp();
        exp_bin[1] = 64;
        dump("c1", 1'b0, 1'b1);

        // Cell 2: 64 x 0xFF straight after; bin 1 must have been cleared on read.
        send("c2", 8'hFF, 64);
        wait_dump("c2");
        clear_exp();
        exp_bin[58] = 64;
        dump("c2", 1'b0, 1'b1);

        // Cell 3: mixed codes, junk presented while code_ready is low,
        // toggling hist_ready with a long stall mid-dump.
        send("c3", 8'hFF, 1);
        send("c3", 8'h05, 1);
        send("c3", 8'h80, 1);
        send("c3", 8'h0E, 1);
        send("c3", 8'h07, 60);
        code_valid = 1'b1;
        code_in    = 8'h05;
        wait_dump("c3");
        clear_exp();
        exp_bin[58] = 1;
        exp_bin[0]  = 1;
        exp_bin[30] = 1;
        exp_bin[10] = 1;
        exp_bin[7]  = 60;
        dump("c3", 1'b1, 1'b0);

        // Cell 4: reset after 30 codes abandons them; then a full cell of 0x80.
        send("c4a", 8'h00, 30);
        do_reset("mid");
        send("c4", 8'h80, 64);
        wait_dump("c4");
        clear_exp();
        exp_bin[30] = 64;
        dump("c4", 1'b0, 1'b1);

        // Small instance: 20 x 0xFF into 4-bit counters saturates at 15.
        check("sat_code_ready", 32'(code_ready2), 1);
        code_valid2 = 1'b1;
        code_in2    = 8'hFF;
        for (int i = 0; i < 20; i++) tick();
        code_valid2 = 1'b0;
        check("sat_code_ready_done", 32'(code_ready2), 0);
        w = 0;
        while (!hist_valid2 && w < 20) begin
            tick();
            w++;
        end
        check("sat_dump_start", 32'(hist_valid2), 1);
        hist_ready2 = 1'b1;
        for (int b = 0; b < 59; b++) begin
            check("sat_bin", 32'(hist_bin2), 32'(b));
            check("sat_count", 32'(hist_count2), (b == 58) ? 32'd15 : 32'd0);
            check("sat_last", 32'(hist_last2), (b == 58) ? 32'd1 : 32'd0);
            tick();
        end
        hist_ready2 = 1'b0;
        check("sat_post_valid", 32'(hist_valid2), 0);
        check("sat_post_code_ready", 32'(code_ready2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lbp_cell_histogram.md
# lbp_cell_histogram

Builds the uniform-LBP histogram for one image cell. It accepts a stream of 8-bit LBP codes, maps each to a bin 0..58 through the uniform-pattern LUT (bin 0 = non-uniform, 1..58 = uniform), and accumulates the per-bin counts. Once CELL_PIXELS codes have been committed, it streams out all 59 bins over a valid/ready handshake and clears each bin as it is sent. It sits between the LBP operator and the descriptor/classifier stage of the vision processor.

## Interface
- CELL_PIXELS, 64: number of codes per cell (1..65535).
- COUNT_WIDTH, 8: width of each bin counter; counts saturate at 2^COUNT_WIDTH-1.
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- code_valid  input  1  code_in is valid.
- code_in  input  8  raw LBP code.
- code_ready  output  1  block accepts a code this cycle.
- hist_valid  output  1  hist_bin/hist_count/hist_last are valid.
- hist_ready  input  1  consumer accepts the current bin.
- hist_bin  output  6  bin index 0..58.
- hist_count  output  COUNT_WIDTH  count of that bin.
- hist_last  output  1  high with bin 58.
- cell_done  output  1  one-cycle pulse on entry to DUMP.
- busy  output  1  high in CLEAR, DRAIN and DUMP.

## Operation
- Storage: 59 x COUNT_WIDTH register array. The LUT is instantiated internally and is registered, with 1-cycle latency.
- Pipeline: in the accept cycle the code goes to the LUT. In the next cycle the LUT output and a valid bit feed stage 2. At the end of stage 2 the bin does count <= (count==max) ? max : count+1.
- Counter pix_cnt (16-bit) counts accepted codes. It resets to 0 on reset and on exit from DUMP.
- State CLEAR (entered from reset): zero bin k in the k-th cycle after reset deasserts, k = 0..58, then go to ACCUM.
- State ACCUM: code_ready = 1 while pix_cnt < CELL_PIXELS. A code is accepted when code_valid && code_ready. When the CELL_PIXELS-th code is accepted, go to DRAIN; code_ready is 0 from the next cycle.
- State DRAIN: wait until the stage-2 valid bit is clear (last increment committed), then go to DUMP and pulse cell_done.
- State DUMP: bin pointer starts at 0. hist_valid = 1. hist_bin = pointer, hist_count = array[pointer], hist_last = (pointer == 58).
  - On hist_valid && hist_ready: write array[pointer] <= 0 and increment the pointer.
  - On the handshake with hist_last: go to ACCUM with pix_cnt = 0. No CLEAR pass is needed because every bin was zeroed during readout.
- Outputs must stay stable while hist_valid && !hist_ready. The stall may be unbounded; code_ready stays 0 throughout.
- Reset at any time: abandon the partial histogram, flush the pipeline valid bits, clear pix_cnt, and enter CLEAR.

## Timing
- Reset values (during reset and the cycle after): code_ready 0, hist_valid 0, hist_bin 0, hist_count 0, hist_last 0, cell_done 0, busy 1.
- CLEAR lasts 59 cycles. With reset low from cycle 0, code_ready first goes high in cycle 59.
- Back-to-back throughput: one code per cycle, with no hazards. Stage 2 reads and writes the same register in one cycle, so consecutive identical bins increment correctly.
- Final code accepted in cycle N: cycle N+1 has the LUT output, cycle N+2 commits the increment, and cycle N+3 has hist_valid = 1 and cell_done = 1.
- With hist_ready held high, DUMP takes exactly 59 cycles. code_ready is high again in the cycle after the hist_last handshake.
- Bins read out in DUMP always reflect every committed code; no increment is pending in DUMP.
- Codes presented while code_ready = 0 are ignored and not counted.

## Test plan
- Reset, then CELL_PIXELS = 64 codes of 0x00 back-to-back -> bin 1 = 64, all other bins 0. hist_valid first high 3 cycles after the last accept. Exactly 59 beats, hist_last only on bin 58.
- Codes 0xFF, 0x05, 0x80, 0x0E, then 60 codes of 0x07 -> bin 58 = 1, bin 0 = 1, bin 30 = 1, bin 10 = 1, bin 7 = 60, all others 0.
- With COUNT_WIDTH = 4 and CELL_PIXELS = 20: 20 codes of 0xFF -> bin 58 saturates at 15. No wrap to 0.
- hist_ready toggled randomly, plus a 100-cycle low stall mid-DUMP -> outputs stable during stall, no bin skipped or repeated, code_ready 0 throughout.
- Two cells in sequence (all 0x00, then all 0xFF) -> second dump shows bin 1 = 0 and bin 58 = 64. Proves clear-on-read.
- Reset asserted mid-ACCUM after 30 codes, then a full cell of 0x80 -> 59-cycle CLEAR with code_ready 0, then dump shows bin 30 = 64 only.
